cnn_window3x3: RTL



---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_line_mem.sv | 31 +++
 rtl/cnn_window3x3.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared sizing defaults and 3x3 window element indices
package cnn_pkg;

   localparam int CNN_W_SIZE    = 12;
   localparam int CNN_W_DATA    = 8;
   localparam int CNN_MAX_WIDTH = 1024;

   // Element k = 3*dr + dc, dr/dc = 0 at the top-left of the window
   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_C  = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;

endpackage

// File: rtl/cnn_line_mem.sv
// rtl/cnn_line_mem.sv - simple dual-port line buffer RAM, read-first on address collision
module cnn_line_mem #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port; the array has no reset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Registered read; a same-edge write lands after this read, so old data is returned
   always_ff @(posedge clk) begin
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_window3x3.sv
// rtl/cnn_window3x3.sv - 3x3 convolution window generator with 1x1 pass-through
module cnn_window3x3
   import cnn_pkg::*;
#(
   parameter int W_SIZE       = CNN_W_SIZE,
   parameter int W_DATA       = CNN_W_DATA,
   parameter int MAX_WIDTH    = CNN_MAX_WIDTH,
   parameter int W_FRAME_SIZE = 2*W_SIZE+1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    q_is_conv3x3,
   input  logic [W_SIZE-1:0]       q_width,
   input  logic [W_SIZE-1:0]       q_height,
   input  logic                    i_data_run,
   input  logic [W_SIZE-1:0]       i_row,
   input  logic [W_SIZE-1:0]       i_col,
   input  logic                    i_end_frame,
   input  logic [W_DATA-1:0]       i_pixel,
   output logic                    o_win_valid,
   output logic [9*W_DATA-1:0]     o_win,
   output logic [W_SIZE-1:0]       o_win_row,
   output logic [W_SIZE-1:0]       o_win_col,
   output logic [W_FRAME_SIZE-1:0] o_win_count,
   output logic                    o_end_frame,
   output logic                    o_cfg_err
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   logic                    cfg_err;
   logic                    accept;
   logic                    lb1_wr_en;
   logic [W_DATA-1:0]       lb0_rd;
   logic [W_DATA-1:0]       lb1_rd;

   logic                    s1_valid_q, s1_valid_d;
   logic [W_DATA-1:0]       s1_pixel_q, s1_pixel_d;
   logic [W_SIZE-1:0]       s1_row_q,   s1_row_d;
   logic [W_SIZE-1:0]       s1_col_q,   s1_col_d;
   logic                    s1_end_q,   s1_end_d;

   logic [9*W_DATA-1:0]     win_q,       win_d;
   logic                    win_valid_q, win_valid_d;
   logic [W_SIZE-1:0]       win_row_q,   win_row_d;
   logic [W_SIZE-1:0]       win_col_q,   win_col_d;
   logic [W_FRAME_SIZE-1:0] win_count_q, win_count_d;
   logic                    end_frame_q, end_frame_d;

   // Reject widths the line buffers cannot hold and frames too small for any 3x3 window
   always_comb begin
      cfg_err = ({1'b0, q_width} > (W_SIZE+1)'(MAX_WIDTH));
      if (q_is_conv3x3 && ((q_width < W_SIZE'(3)) || (q_height < W_SIZE'(3)))) cfg_err = 1'b1;
   end

   assign accept    = i_data_run & ~cfg_err;
   assign lb1_wr_en = s1_valid_q & ~cfg_err;

   // LB0 holds row r-1: read old value and overwrite with the current pixel
   cnn_line_mem #(.DEPTH(MAX_WIDTH), .WIDTH(W_DATA), .AW(AW)) u_lb0 (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (i_col[AW-1:0]),
      .wr_data (i_pixel),
      .rd_en   (accept),
      .rd_addr (i_col[AW-1:0]),
      .rd_data (lb0_rd)
   );

   // LB1 holds row r-2: it is refilled one stage later with what LB0 just returned
   cnn_line_mem #(.DEPTH(MAX_WIDTH), .WIDTH(W_DATA), .AW(AW)) u_lb1 (
      .clk     (clk),
      .wr_en   (lb1_wr_en),
      .wr_addr (s1_col_q[AW-1:0]),
      .wr_data (lb0_rd),
      .rd_en   (accept),
      .rd_addr (i_col[AW-1:0]),
      .rd_data (lb1_rd)
   );

   // Stage 1: hold the accepted pixel and its coordinates next to the line-buffer reads
   always_comb begin
      s1_valid_d = accept;
      s1_pixel_d = s1_pixel_q;
      s1_row_d   = s1_row_q;
      s1_col_d   = s1_col_q;
      s1_end_d   = s1_end_q;
      if (accept) begin
         s1_pixel_d = i_pixel;
         s1_row_d   = i_row;
         s1_col_d   = i_col;
         s1_end_d   = i_end_frame;
      end
   end

   // Stage 2: shift in the new column (3x3) or place the lone pixel (1x1), and count windows
   always_comb begin
      win_d       = win_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      win_valid_d = 1'b0;
      end_frame_d = 1'b0;
      win_count_d = end_frame_q ? '0 : win_count_q;
      if (s1_valid_q && !cfg_err) begin
         if (q_is_conv3x3) begin
            win_d[WIN_TL*W_DATA +: W_DATA] = win_q[WIN_TC*W_DATA +: W_DATA];
            win_d[WIN_TC*W_DATA +: W_DATA] = win_q[WIN_TR*W_DATA +: W_DATA];
            win_d[WIN_TR*W_DATA +: W_DATA] = lb1_rd;
            win_d[WIN_ML*W_DATA +: W_DATA] = win_q[WIN_C*W_DATA  +: W_DATA];
            win_d[WIN_C*W_DATA  +: W_DATA] = win_q[WIN_MR*W_DATA +: W_DATA];
            win_d[WIN_MR*W_DATA +: W_DATA] = lb0_rd;
            win_d[WIN_BL*W_DATA +: W_DATA] = win_q[WIN_BC*W_DATA +: W_DATA];
            win_d[WIN_BC*W_DATA +: W_DATA] = win_q[WIN_BR*W_DATA +: W_DATA];
            win_d[WIN_BR*W_DATA +: W_DATA] = s1_pixel_q;
            win_row_d   = s1_row_q - W_SIZE'(1);
            win_col_d   = s1_col_q - W_SIZE'(1);
            win_valid_d = (s1_row_q >= W_SIZE'(2)) && (s1_col_q >= W_SIZE'(2));
         end else begin
            win_d = '0;
            win_d[WIN_C*W_DATA +: W_DATA] = s1_pixel_q;
            win_row_d   = s1_row_q;
            win_col_d   = s1_col_q;
            win_valid_d = 1'b1;
         end
         end_frame_d = s1_end_q;
         if (win_valid_d) win_count_d = win_count_d + W_FRAME_SIZE'(1);
      end
   end

   // Pipeline and window registers; line memory contents are deliberately left alone
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_pixel_q  <= '0;
         s1_row_q    <= '0;
         s1_col_q    <= '0;
         s1_end_q    <= 1'b0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         win_count_q <= '0;
         end_frame_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pixel_q  <= s1_pixel_d;
         s1_row_q    <= s1_row_d;
         s1_col_q    <= s1_col_d;
         s1_end_q    <= s1_end_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         win_count_q <= win_count_d;
         end_frame_q <= end_frame_d;
      end
   end

   assign o_cfg_err   = cfg_err;
   assign o_win_valid = win_valid_q & ~cfg_err;
   assign o_end_frame = end_frame_q & ~cfg_err;
   assign o_win       = win_q;
   assign o_win_row   = win_row_q;
   assign o_win_col   = win_col_q;
   assign o_win_count = win_count_q;

endmodule
